// File: rtl/uart_pkg.sv
// Shared types for the UART transmit (and future receive) paths.
package uart_pkg;

  localparam int UART_MIN_DATA_BITS = 5;
  // Frame divider storage width; baud_div is zero-extended into it, so DIV_WID must not exceed it.
  localparam int UART_DIV_W = 32;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_tx_state_e;

  typedef struct packed {
    logic [1:0]            data_bits;
    logic                  parity_en;
    logic                  parity_odd;
    logic                  stop2;
    logic [UART_DIV_W-1:0] div;
  } uart_frame_cfg_t;

  // Keeps only the bits that are actually transmitted for a given data length.
  function automatic logic [7:0] data_mask(input logic [1:0] data_bits);
    return 8'hFF >> (2'd3 - data_bits);
  endfunction

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Byte write port into the UART transmit FIFO.
interface uart_tx_fifo_if #(
  parameter int LVL_WID = 4
);
  logic               wr_valid;
  logic [7:0]         wr_data;
  logic               wr_ready;
  logic [LVL_WID-1:0] fifo_level;

  modport master (output wr_valid, wr_data, input wr_ready, fifo_level);
  modport slave  (input wr_valid, wr_data, output wr_ready, fifo_level);
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; no fall-through, head is read combinationally.
module sync_fifo #(
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 8,
  parameter int LVL_WID = $clog2(DEPTH) + 1
) (
  input  logic               hclk,
  input  logic               hresetn,
  input  logic               push,
  input  logic [WIDTH-1:0]   push_data,
  input  logic               pop,
  output logic [WIDTH-1:0]   pop_data,
  output logic [LVL_WID-1:0] level,
  output logic               full,
  output logic               empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (level == LVL_WID'(DEPTH));
  assign empty    = (level == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // NOTE: storage has no reset; the level and pointers guarantee stale entries are never read.
  always_ff @(posedge hclk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + LVL_WID'(1);
        2'b01:   level <= level - LVL_WID'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// FIFO-buffered UART transmitter: 5-8 data bits, optional parity, 1 or 2 stop bits, LSB first.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DIV_WID    = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int LVL_WID    = $clog2(FIFO_DEPTH) + 1
) (
  input  logic               hclk,
  input  logic               hresetn,
  input  logic [DIV_WID-1:0] baud_div,
  input  logic [1:0]         cfg_data_bits,
  input  logic               cfg_parity_en,
  input  logic               cfg_parity_odd,
  input  logic               cfg_stop2,
  uart_tx_fifo_if.slave      wr_bus,
  output logic               tx_busy,
  output logic               tx_done,
  output logic               uart_txd
);

  uart_tx_state_e        state_q, state_n;
  uart_frame_cfg_t       frame_q, cfg_in;
  logic [UART_DIV_W-1:0] cnt_q;
  logic [2:0]            idx_q;
  logic [7:0]            shift_q;
  logic [7:0]            data_q;
  logic [7:0]            fifo_head;
  logic [LVL_WID-1:0]    level;
  logic                  fifo_full, fifo_empty;
  logic                  pop, bit_end, last_data, last_stop;
  logic                  txd_n, done_n;

  sync_fifo #(
    .WIDTH   (8),
    .DEPTH   (FIFO_DEPTH),
    .LVL_WID (LVL_WID)
  ) u_fifo (
    .hclk      (hclk),
    .hresetn   (hresetn),
    .push      (wr_bus.wr_valid),
    .push_data (wr_bus.wr_data),
    .pop       (pop),
    .pop_data  (fifo_head),
    .level     (level),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign wr_bus.wr_ready   = !fifo_full;
  assign wr_bus.fifo_level = level;
  assign tx_busy           = (state_q != IDLE) || (level != '0);

  // Live configuration, sampled into frame_q only when a byte is popped.
  always_comb begin
    cfg_in.data_bits  = cfg_data_bits;
    cfg_in.parity_en  = cfg_parity_en;
    cfg_in.parity_odd = cfg_parity_odd;
    cfg_in.stop2      = cfg_stop2;
    cfg_in.div        = (baud_div == '0) ? UART_DIV_W'(1) : UART_DIV_W'(baud_div);
  end

  assign bit_end   = (cnt_q == frame_q.div - UART_DIV_W'(1));
  assign last_data = (idx_q == 3'(UART_MIN_DATA_BITS - 1) + {1'b0, frame_q.data_bits});
  assign last_stop = (idx_q == {2'b00, frame_q.stop2});

  always_comb begin
    // NOTE: every output gets a default first so no path through the case leaves a latch.
    state_n = state_q;
    pop     = 1'b0;
    done_n  = 1'b0;
    txd_n   = 1'b1;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_n = START;
        end
      end
      START: begin
        txd_n = 1'b0;
        if (bit_end) state_n = DATA;
      end
      DATA: begin
        txd_n = shift_q[0];
        if (bit_end && last_data) state_n = frame_q.parity_en ? PARITY : STOP;
      end
      PARITY: begin
        txd_n = ^(data_q & data_mask(frame_q.data_bits)) ^ frame_q.parity_odd;
        if (bit_end) state_n = STOP;
      end
      STOP: begin
        if (bit_end && last_stop) begin
          done_n = 1'b1;
          // Chain straight into the next start bit when more data is queued.
          if (!fifo_empty) begin
            pop     = 1'b1;
            state_n = START;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q  <= IDLE;
      frame_q  <= '0;
      cnt_q    <= '0;
      idx_q    <= '0;
      shift_q  <= '0;
      data_q   <= '0;
      uart_txd <= 1'b1;
      tx_done  <= 1'b0;
    end else begin
      // NOTE: non-blocking only; a blocking write would let later lines see this edge's new value.
      state_q  <= state_n;
      uart_txd <= txd_n;
      tx_done  <= done_n;
      if (pop) begin
        frame_q <= cfg_in;
        shift_q <= fifo_head;
        data_q  <= fifo_head;
        cnt_q   <= '0;
        idx_q   <= '0;
      end else if (state_q != IDLE) begin
        if (bit_end) begin
          cnt_q <= '0;
          idx_q <= (state_n == state_q) ? idx_q + 3'd1 : 3'd0;
          if (state_q == DATA) shift_q <= shift_q >> 1;
        end else begin
          cnt_q <= cnt_q + UART_DIV_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench: frame-level reference model compared every cycle, plus directed literal checks.
module tb_uart_tx_fifo;

  localparam int DEPTH   = 8;
  localparam int LVL_WID = $clog2(DEPTH) + 1;

  logic               hclk = 1'b0;
  logic               hresetn = 1'b0;
  logic [15:0]        baud_div = 16'd4;
  logic [1:0]         cfg_data_bits = 2'd3;
  logic               cfg_parity_en = 1'b0;
  logic               cfg_parity_odd = 1'b0;
  logic               cfg_stop2 = 1'b0;
  logic               wr_valid = 1'b0;
  logic [7:0]         wr_data = 8'h00;
  logic               wr_ready;
  logic [LVL_WID-1:0] fifo_level;
  logic               tx_busy, tx_done, uart_txd;

  int n_checks = 0;
  int n_fail   = 0;

  uart_tx_fifo_if #(.LVL_WID(LVL_WID)) wr_bus ();
  assign wr_bus.wr_valid = wr_valid;
  assign wr_bus.wr_data  = wr_data;
  assign wr_ready        = wr_bus.wr_ready;
  assign fifo_level      = wr_bus.fifo_level;

  uart_tx_fifo #(
    .DIV_WID    (16),
    .FIFO_DEPTH (DEPTH),
    .LVL_WID    (LVL_WID)
  ) dut (
    .hclk           (hclk),
    .hresetn        (hresetn),
    .baud_div       (baud_div),
    .cfg_data_bits  (cfg_data_bits),
    .cfg_parity_en  (cfg_parity_en),
    .cfg_parity_odd (cfg_parity_odd),
    .cfg_stop2      (cfg_stop2),
    .wr_bus         (wr_bus),
    .tx_busy        (tx_busy),
    .tx_done        (tx_done),
    .uart_txd       (uart_txd)
  );

  always #5 hclk = ~hclk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Byte queue for the FIFO, a per-cycle queue of {done, txd} for the line,
  // and the number of engine cycles left in the frame being sent.
  logic [7:0] mq[$];
  logic [1:0] line_q[$];
  int         rem = 0;
  logic       exp_txd = 1'b1, exp_done = 1'b0, exp_busy = 1'b0, exp_ready = 1'b1;
  int         exp_level = 0;

  task automatic build_frame(input logic [7:0] b, output int len);
    logic bits[$];
    int   n, d, ones;
    n    = 5 + int'(cfg_data_bits);
    d    = (baud_div == 16'd0) ? 1 : int'(baud_div);
    ones = 0;
    bits.push_back(1'b0);
    for (int i = 0; i < n; i++) begin
      bits.push_back(b[i]);
      if (b[i]) ones++;
    end
    if (cfg_parity_en) bits.push_back(((ones % 2) == 1) ^ cfg_parity_odd);
    bits.push_back(1'b1);
    if (cfg_stop2) bits.push_back(1'b1);
    for (int k = 0; k < bits.size(); k++)
      for (int r = 0; r < d; r++)
        line_q.push_back({(k == bits.size() - 1) && (r == d - 1), bits[k]});
    len = bits.size() * d;
  endtask

  initial forever begin
    logic [1:0] ent;
    logic [7:0] head;
    bit         do_push, do_pop;
    int         len;
    @(posedge hclk or negedge hresetn);
    if (!hresetn) begin
      mq.delete();
      line_q.delete();
      rem = 0;
      exp_txd = 1'b1; exp_done = 1'b0; exp_busy = 1'b0; exp_ready = 1'b1; exp_level = 0;
    end else begin
      do_push = wr_valid && (mq.size() < DEPTH);
      do_pop  = (rem <= 1) && (mq.size() > 0);
      ent = (line_q.size() > 0) ? line_q.pop_front() : 2'b01;
      exp_txd  = ent[0];
      exp_done = ent[1];
      if (do_pop) begin
        head = mq.pop_front();
        build_frame(head, len);
        rem = len;
      end else if (rem > 0) begin
        rem--;
      end
      if (do_push) mq.push_back(wr_data);
      exp_level = mq.size();
      exp_ready = (mq.size() < DEPTH);
      exp_busy  = (rem > 0) || (mq.size() > 0);
    end
  end

  // Compare process: every cycle out of reset, mid-cycle.
  initial forever begin
    @(negedge hclk);
    if (hresetn) begin
      check("txd",      32'(uart_txd),   32'(exp_txd));
      check("tx_done",  32'(tx_done),    32'(exp_done));
      check("tx_busy",  32'(tx_busy),    32'(exp_busy));
      check("wr_ready", 32'(wr_ready),   32'(exp_ready));
      check("level",    32'(fifo_level), 32'(exp_level));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic push_byte(input logic [7:0] b);
    wr_valid = 1'b1;
    wr_data  = b;
    @(posedge hclk); #1;
    wr_valid = 1'b0;
  endtask

  task automatic set_cfg(input int div, input int db, input bit pe, input bit po, input bit s2);
    baud_div       = 16'(div);
    cfg_data_bits  = 2'(db);
    cfg_parity_en  = pe;
    cfg_parity_odd = po;
    cfg_stop2      = s2;
  endtask

  task automatic wait_idle();
    int n = 0;
    wr_valid = 1'b0;
    @(negedge hclk);
    while (tx_busy && n < 3000) begin
      @(negedge hclk);
      n++;
    end
    check("idle_timeout", 32'(tx_busy), 32'd0);
    @(posedge hclk); #1;
  endtask

  // Push one byte while idle, record the line, compare bit centres and frame length to literals.
  task automatic directed_frame(input string name, input logic [7:0] b, input int nbits,
                                input logic [11:0] exp_bits, input int exp_len);
    logic        txd_s[$];
    logic        done_s[$];
    logic [11:0] got;
    int          div, done_idx, n_done;
    div      = (baud_div == 16'd0) ? 1 : int'(baud_div);
    got      = '0;
    done_idx = -1;
    n_done   = 0;
    push_byte(b);
    for (int s = 0; s < exp_len + 4; s++) begin
      @(negedge hclk);
      txd_s.push_back(uart_txd);
      done_s.push_back(tx_done);
    end
    check({name, "_fall"}, 32'({txd_s[1], txd_s[2]}), 32'h2);
    for (int j = 0; j < nbits; j++) got[j] = txd_s[2 + j * div + div - 1];
    check({name, "_bits"}, 32'(got), 32'(exp_bits));
    for (int s = 0; s < done_s.size(); s++)
      if (done_s[s]) begin
        n_done++;
        if (done_idx < 0) done_idx = s;
      end
    check({name, "_ndone"}, 32'(n_done), 32'd1);
    check({name, "_len"}, 32'(done_idx - 1), 32'(exp_len));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx[$];
    int cnt;
    logic saw_done;

    repeat (3) @(posedge hclk);
    #1;
    check("rst_txd",   32'(uart_txd),   32'd1);
    check("rst_ready", 32'(wr_ready),   32'd1);
    check("rst_level", 32'(fifo_level), 32'd0);
    check("rst_busy",  32'(tx_busy),    32'd0);
    check("rst_done",  32'(tx_done),    32'd0);
    hresetn = 1'b1;
    @(posedge hclk); #1;

    // 8N1, div 4, 0x55: 40-cycle frame
    set_cfg(4, 3, 0, 0, 0);
    directed_frame("t1_55", 8'h55, 10, {2'b00, 1'b1, 8'h55, 1'b0}, 40);
    check("t1_busy_end", 32'(tx_busy), 32'd0);

    // 7 data bits, two stop bits, even then odd parity
    wait_idle();
    set_cfg(2, 2, 1, 0, 1);
    directed_frame("t2_even", 8'h03, 11, {1'b0, 2'b11, 1'b0, 7'h03, 1'b0}, 22);
    wait_idle();
    set_cfg(2, 2, 1, 1, 1);
    directed_frame("t2_odd", 8'h03, 11, {1'b0, 2'b11, 1'b1, 7'h03, 1'b0}, 22);

    // baud_div 0 and 1 give the same frame
    wait_idle();
    set_cfg(0, 3, 0, 0, 0);
    directed_frame("t4_div0", 8'hC6, 10, {2'b00, 1'b1, 8'hC6, 1'b0}, 10);
    wait_idle();
    set_cfg(1, 3, 0, 0, 0);
    directed_frame("t4_div1", 8'hC6, 10, {2'b00, 1'b1, 8'hC6, 1'b0}, 10);

    // data length changed mid-frame: 8-bit frame then 5-bit frame
    wait_idle();
    push_byte(8'hFF);
    wr_valid = 1'b1;
    wr_data  = 8'h00;
    @(posedge hclk); #1;
    wr_valid      = 1'b0;
    cfg_data_bits = 2'd0;
    for (int i = 0; i < 22; i++) begin
      @(negedge hclk);
      if (tx_done) idx.push_back(i);
    end
    check("t4_ndone", 32'(idx.size()), 32'd2);
    if (idx.size() == 2) begin
      check("t4_done1", 32'(idx[0]), 32'd10);
      check("t4_done2", 32'(idx[1]), 32'd17);
    end

    // nine back-to-back pushes at div 1 fill the FIFO; a tenth is dropped
    wait_idle();
    set_cfg(1, 3, 0, 0, 0);
    for (int i = 0; i < 9; i++) begin
      wr_valid = 1'b1;
      wr_data  = 8'(8'h10 + i);
      @(posedge hclk); #1;
    end
    wr_data = 8'hEE;
    @(negedge hclk);
    check("t3_level_full", 32'(fifo_level), 32'd8);
    check("t3_ready_low",  32'(wr_ready),   32'd0);
    @(posedge hclk); #1;
    wr_valid = 1'b0;
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge hclk);
      if (tx_done) cnt++;
    end
    check("t3_frames", 32'(cnt), 32'd9);

    // push coinciding with the internal pop at level 3
    wait_idle();
    for (int i = 0; i < 4; i++) push_byte(8'(8'h30 + i));
    repeat (7) @(posedge hclk);
    #1;
    push_byte(8'h99);
    @(negedge hclk);
    check("t6_done", 32'(tx_done),    32'd1);
    check("t6_level", 32'(fifo_level), 32'd3);

    // reset in the middle of a data bit
    wait_idle();
    wait_idle();
    set_cfg(4, 3, 0, 0, 0);
    push_byte(8'hA5);
    push_byte(8'h5A);
    repeat (10) @(posedge hclk);
    @(negedge hclk);
    check("t5_pre_txd", 32'(uart_txd), 32'd0);
    #2;
    hresetn = 1'b0;
    #1;
    check("t5_txd",   32'(uart_txd),   32'd1);
    check("t5_level", 32'(fifo_level), 32'd0);
    check("t5_busy",  32'(tx_busy),    32'd0);
    saw_done = 1'b0;
    repeat (4) begin
      @(negedge hclk);
      saw_done = saw_done | tx_done;
    end
    check("t5_no_done", 32'(saw_done), 32'd0);
    @(posedge hclk); #1;
    hresetn = 1'b1;
    @(posedge hclk); #1;
    directed_frame("t5_a5", 8'hA5, 10, {2'b00, 1'b1, 8'hA5, 1'b0}, 40);

    // randomized traffic with config changes, including mid-frame
    wait_idle();
    for (int phase = 0; phase < 3; phase++) begin
      int pct;
      pct = (phase == 0) ? 8 : (phase == 1) ? 35 : 70;
      for (int c = 0; c < 2500; c++) begin
        if ($urandom_range(0, 99) < 3)
          set_cfg(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        wr_valid = ($urandom_range(0, 99) < pct);
        wr_data  = 8'($urandom);
        @(posedge hclk); #1;
      end
    end
    wait_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
